// File: rtl/digest_phrase.sv
// 128-bit to 16-bit width converter: each accepted phrase streams out as eight
// words, least-significant word first, with valid/ready on both sides.
module digest_phrase (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         valid_phrase,
  output logic         ready_phrase,
  input  logic [127:0] phrase_data,
  output logic         valid_word,
  input  logic         ready_word,
  output logic [15:0]  word
);

  logic [127:0] r_buf;
  logic [2:0]   r_idx;
  logic         r_full;

  logic w_last;
  logic w_phrase_xfer;
  logic w_word_xfer;

  assign w_last        = r_full && (r_idx == 3'd7);
  // The last word leaving this cycle frees the buffer, so a new phrase can land on the same edge.
  assign ready_phrase  = rst_in && (!r_full || (w_last && ready_word));
  assign w_phrase_xfer = valid_phrase && ready_phrase;
  assign w_word_xfer   = r_full && ready_word;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (w_phrase_xfer) begin
      r_buf  <= phrase_data;
      r_idx  <= '0;
      r_full <= 1'b1;
    end else if (w_word_xfer) begin
      if (r_idx == 3'd7) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign valid_word = r_full;
  assign word       = r_full ? r_buf[{r_idx, 4'b0000} +: 16] : 16'h0000;

endmodule

// File: tb/tb_digest_phrase.sv
// Bench for digest_phrase: directed scenarios plus random traffic, checked
// against a queue model of the words still owed to the consumer.
module tb_digest_phrase;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         valid_phrase;
  logic         ready_phrase;
  logic [127:0] phrase_data;
  logic         valid_word;
  logic         ready_word;
  logic [15:0]  word;

  int checks = 0;
  int passes = 0;

  logic [15:0] mq[$];

  localparam logic [127:0] P1 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] P3 = 128'hABBA_ACDC_BEEF_FEED_DEEF_FEEB_CDCA_ABBA;
  localparam logic [127:0] P4 = 128'h3141_5926_5358_9793_2384_6264_3383_def0;
  localparam logic [127:0] P5 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  digest_phrase dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_phrase (valid_phrase),
    .ready_phrase (ready_phrase),
    .phrase_data  (phrase_data),
    .valid_word   (valid_word),
    .ready_word   (ready_word),
    .word         (word)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic exp_rp();
    return rst_in && (mq.size() == 0 || (mq.size() == 1 && ready_word));
  endfunction

  function automatic logic exp_vw();
    return mq.size() > 0;
  endfunction

  function automatic logic [15:0] exp_w();
    return (mq.size() > 0) ? mq[0] : 16'h0000;
  endfunction

  task automatic apply(input logic vp, input logic [127:0] pd, input logic rw);
    @(negedge clk_in);
    valid_phrase = vp;
    phrase_data  = pd;
    ready_word   = rw;
    #1;
  endtask

  // Advance one edge; the model pops a transferred word and replaces the queue on a phrase load.
  task automatic tick();
    logic wx, px;
    logic [127:0] pd;
    wx = (mq.size() > 0) && ready_word;
    px = valid_phrase && exp_rp();
    pd = phrase_data;
    @(posedge clk_in);
    if (wx) void'(mq.pop_front());
    if (px) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mq.push_back(pd[16*i +: 16]);
    end
  endtask

  task automatic test_reset();
    apply(1'b0, P1, 1'b1);
    checks++;
    if ({ready_phrase, valid_word, word} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_hold: got rp=%b vw=%b word=%h, want rp=0 vw=0 word=0000", ready_phrase, valid_word, word);
    else passes++;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checks++;
    if ({ready_phrase, valid_word, word} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL reset_release: got rp=%b vw=%b word=%h, want rp=1 vw=0 word=0000", ready_phrase, valid_word, word);
    else passes++;
  endtask

  task automatic test_start();
    apply(1'b1, P1, 1'b1);
    checks++;
    if ({ready_phrase, valid_word} !== 2'b10)
      $display("FAIL start_accept: got rp=%b vw=%b, want rp=1 vw=0", ready_phrase, valid_word);
    else passes++;
    tick();
    for (int i = 0; i < 8; i++) begin
      apply(i == 7, P2, 1'b1);
      checks++;
      if ({valid_word, word} !== {1'b1, (i == 0) ? 16'h0001 : 16'h0000})
        $display("FAIL start_word%0d: got vw=%b word=%h, want vw=1 word=%h", i, valid_word, word, (i == 0) ? 16'h0001 : 16'h0000);
      else passes++;
      if (i == 7) begin
        checks++;
        if (ready_phrase !== 1'b1)
          $display("FAIL start_last_ready: got rp=%b, want rp=1", ready_phrase);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wexp [10] = '{16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444,
                               16'h4444, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, P3, !(k == 4 || k == 5));
      checks++;
      if ({valid_word, word} !== {1'b1, wexp[k]} || ready_phrase !== exp_rp())
        $display("FAIL b2b_stall_word%0d: got rp=%b vw=%b word=%h, want rp=%b vw=1 word=%h",
                 k, ready_phrase, valid_word, word, exp_rp(), wexp[k]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_source_stall();
    logic [15:0] wexp [7] = '{16'hABBA, 16'hCDCA, 16'hFEEB, 16'hDEEF, 16'hFEED, 16'hBEEF, 16'hACDC};
    apply(1'b0, P3, 1'b1);
    checks++;
    if ({ready_phrase, valid_word, word} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL src_stall_empty: got rp=%b vw=%b word=%h, want rp=1 vw=0 word=0000", ready_phrase, valid_word, word);
    else passes++;
    tick();
    apply(1'b1, P3, 1'b1);
    checks++;
    if ({ready_phrase, valid_word} !== 2'b10)
      $display("FAIL src_stall_accept: got rp=%b vw=%b, want rp=1 vw=0", ready_phrase, valid_word);
    else passes++;
    tick();
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, P4, 1'b1);
      checks++;
      if ({valid_word, word} !== {1'b1, wexp[k]})
        $display("FAIL src_stall_word%0d: got vw=%b word=%h, want vw=1 word=%h", k, valid_word, word, wexp[k]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_boundary_stall();
    logic [15:0] wexp [3] = '{16'hdef0, 16'h3383, 16'h6264};
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, P4, 1'b0);
      checks++;
      if ({ready_phrase, valid_word, word} !== {1'b0, 1'b1, 16'hABBA})
        $display("FAIL bound_hold%0d: got rp=%b vw=%b word=%h, want rp=0 vw=1 word=abba", k, ready_phrase, valid_word, word);
      else passes++;
      tick();
    end
    apply(1'b1, P4, 1'b1);
    checks++;
    if ({ready_phrase, valid_word, word} !== {1'b1, 1'b1, 16'hABBA})
      $display("FAIL bound_release: got rp=%b vw=%b word=%h, want rp=1 vw=1 word=abba", ready_phrase, valid_word, word);
    else passes++;
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, P5, 1'b1);
      checks++;
      if ({valid_word, word} !== {1'b1, wexp[k]})
        $display("FAIL bound_word%0d: got vw=%b word=%h, want vw=1 word=%h", k, valid_word, word, wexp[k]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b0, P5, 1'b0);
    checks++;
    if ({valid_word, word} !== {1'b1, 16'h2384})
      $display("FAIL midrst_before: got vw=%b word=%h, want vw=1 word=2384", valid_word, word);
    else passes++;
    rst_in = 1'b0;
    mq.delete();
    #1;
    checks++;
    if ({ready_phrase, valid_word, word} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL midrst_async: got rp=%b vw=%b word=%h, want rp=0 vw=0 word=0000", ready_phrase, valid_word, word);
    else passes++;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    apply(1'b1, P5, 1'b1);
    checks++;
    if ({ready_phrase, valid_word} !== 2'b10)
      $display("FAIL midrst_accept: got rp=%b vw=%b, want rp=1 vw=0", ready_phrase, valid_word);
    else passes++;
    tick();
    apply(1'b0, P5, 1'b1);
    checks++;
    if ({valid_word, word} !== {1'b1, 16'h3210})
      $display("FAIL midrst_word0: got vw=%b word=%h, want vw=1 word=3210", valid_word, word);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [127:0] pd;
    for (int n = 0; n < 400; n++) begin
      pd = {$urandom, $urandom, $urandom, $urandom};
      apply($urandom_range(0, 3) != 0, pd, $urandom_range(0, 3) != 0);
      checks++;
      if ({ready_phrase, valid_word, word} !== {exp_rp(), exp_vw(), exp_w()})
        $display("FAIL random_cycle%0d: got rp=%b vw=%b word=%h, want rp=%b vw=%b word=%h",
                 n, ready_phrase, valid_word, word, exp_rp(), exp_vw(), exp_w());
      else passes++;
      tick();
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    valid_phrase = 1'b0;
    phrase_data  = '0;
    ready_word   = 1'b0;
    #2 rst_in = 1'b0;
    test_reset();
    test_start();
    test_back_to_back();
    test_source_stall();
    test_boundary_stall();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
